// File: rtl/bounce_emu_pkg.sv
// Shared types and constants for the switch-bounce emulator.
// Optional build macro BOUNCE_EMU_RELEASE_EN is consumed by bounce_emulator.
package bounce_emu_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } bounce_state_e;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] fixed_s;
    if (seed == 16'h0000) begin
      fixed_s = 16'h0001;
    end else begin
      fixed_s = seed;
    end
    return fixed_s;
  endfunction

endpackage

// File: rtl/bounce_emu_if.sv
// Clean-level in / bouncy-level out bundle between a pattern source and the emulator.
interface bounce_emu_if;

  logic i_Clean;
  logic o_Bouncy;
  logic o_Busy;
  logic o_Done;

  modport master (
    output i_Clean,
    input  o_Bouncy,
    input  o_Busy,
    input  o_Done
  );

  modport slave (
    input  i_Clean,
    output o_Bouncy,
    output o_Busy,
    output o_Done
  );

endinterface

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400) that reloads its seed on reset.
module bounce_lfsr
  import bounce_emu_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  output logic [LFSR_W-1:0] o_Lfsr
);

  localparam logic [LFSR_W-1:0] SEED_FIX = seed_fix(SEED);

  logic [LFSR_W-1:0] lfsr_r;
  logic [LFSR_W-1:0] lfsr_next_s;

  // Galois step: shift right, fold the taps in when a one falls out.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[LFSR_W-1:1]};
    if (lfsr_r[0]) begin
      lfsr_next_s = lfsr_next_s ^ LFSR_TAPS;
    end else begin
      lfsr_next_s = lfsr_next_s;
    end
  end

  // LFSR state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      lfsr_r <= SEED_FIX;
    end else begin
      lfsr_r <= lfsr_next_s;
    end
  end

  assign o_Lfsr = lfsr_r;

endmodule

// File: rtl/bounce_emulator.sv
// Emits a pseudo-random chatter burst after each clean-level change, then settles.
// Define BOUNCE_EMU_RELEASE_EN to bounce on release (1->0) as well as press.
module bounce_emulator
  import bounce_emu_pkg::*;
#(
  parameter int               BOUNCE_LIMIT = 125000,
  parameter int               CHATTER_DIV  = 1024,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  bounce_emu_if.slave emu
);

  localparam int CNT_W = $clog2(BOUNCE_LIMIT);
  localparam int DIV_W = (CHATTER_DIV > 1) ? $clog2(CHATTER_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_LIMIT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHATTER_DIV - 1);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_BOUNCE = BOUNCE;

  logic [0:0]        state_r,  state_s;
  logic              level_r,  level_s;
  logic              target_r, target_s;
  logic [CNT_W-1:0]  cnt_r,    cnt_s;
  logic [DIV_W-1:0]  div_r,    div_s;
  logic              bouncy_r, bouncy_s;
  logic              busy_r,   busy_s;
  logic              done_r,   done_s;
  logic              run_window_s;
  logic [LFSR_W-1:0] lfsr_s;
  logic              unused_lfsr_s;

  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .o_Lfsr  (lfsr_s)
  );

  // Only bit 0 drives chatter; the rest is sequence state.
  assign unused_lfsr_s = ^lfsr_s[LFSR_W-1:1];

`ifdef BOUNCE_EMU_RELEASE_EN
  assign run_window_s = 1'b1;
`else
  assign run_window_s = emu.i_Clean;
`endif

  // div_r tracks counter % CHATTER_DIV without a divider.
  always_comb begin
    state_s  = state_r;
    level_s  = level_r;
    target_s = target_r;
    cnt_s    = cnt_r;
    div_s    = div_r;
    bouncy_s = bouncy_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (emu.i_Clean != level_r) begin
          if (run_window_s) begin
            target_s = emu.i_Clean;
            cnt_s    = {CNT_W{1'b0}};
            div_s    = {DIV_W{1'b0}};
            bouncy_s = emu.i_Clean;
            busy_s   = 1'b1;
            state_s  = ST_BOUNCE;
          end else begin
            bouncy_s = 1'b0;
            level_s  = 1'b0;
            done_s   = 1'b1;
          end
        end else begin
          bouncy_s = level_r;
        end
      end
      ST_BOUNCE: begin
        if (emu.i_Clean != target_r) begin
          target_s = emu.i_Clean;
          cnt_s    = {CNT_W{1'b0}};
          div_s    = {DIV_W{1'b0}};
          bouncy_s = emu.i_Clean;
        end else if (cnt_r == CNT_LAST) begin
          bouncy_s = target_r;
          level_s  = target_r;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
          if (div_r == DIV_LAST) begin
            div_s    = {DIV_W{1'b0}};
            bouncy_s = lfsr_s[0];
          end else begin
            div_s    = div_r + DIV_W'(1);
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any window with no settle pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r  <= ST_IDLE;
      level_r  <= 1'b0;
      target_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      div_r    <= {DIV_W{1'b0}};
      bouncy_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      level_r  <= level_s;
      target_r <= target_s;
      cnt_r    <= cnt_s;
      div_r    <= div_s;
      bouncy_r <= bouncy_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign emu.o_Bouncy = bouncy_r;
  assign emu.o_Busy   = busy_r;
  assign emu.o_Done   = done_r;

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: cycle model feeds a scoreboard, plus a debounce-filter loopback.
module tb_bounce_emulator;

  localparam int LIMIT = 64;
  localparam int DIV   = 4;
  localparam int FILT_LIMIT = 128;
`ifdef BOUNCE_EMU_RELEASE_EN
  localparam bit RELEASE_BOUNCES = 1'b1;
`else
  localparam bit RELEASE_BOUNCES = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  bounce_emu_if emu_if ();

  bounce_emulator #(
    .BOUNCE_LIMIT (LIMIT),
    .CHATTER_DIV  (DIV),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (reset),
    .emu     (emu_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic bouncy;
    logic busy;
    logic done;
  } obs_t;

  obs_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic        m_bounce_st;
  logic        m_level, m_target, m_bouncy, m_busy, m_done;
  int          m_cnt;
  logic [15:0] m_lfsr;

  int   busy_cnt, done_cnt;
  int   rec_mode = 0;
  int   rec_idx;
  logic rec_a[LIMIT];
  logic rec_b[LIMIT];

  // loopback debounce filter (counts consecutive differing samples)
  logic f_state = 1'b0;
  int   f_cnt = 0;
  int   f_toggles = 0;

  always @(posedge clk) begin
    if (reset) begin
      f_state <= 1'b0;
      f_cnt   <= 0;
    end else if (emu_if.o_Bouncy !== f_state && f_cnt < FILT_LIMIT - 1) begin
      f_cnt <= f_cnt + 1;
    end else if (f_cnt == FILT_LIMIT - 1) begin
      f_state   <= emu_if.o_Bouncy;
      f_cnt     <= 0;
      f_toggles <= f_toggles + 1;
    end else begin
      f_cnt <= 0;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic clean, input logic rst);
    logic [15:0] cur;
    cur    = m_lfsr;
    m_done = 1'b0;
    if (rst) begin
      m_bounce_st = 1'b0;
      m_level = 1'b0; m_target = 1'b0; m_cnt = 0;
      m_bouncy = 1'b0; m_busy = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      m_lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
      if (!m_bounce_st) begin
        if (clean != m_level) begin
          if (clean || RELEASE_BOUNCES) begin
            m_target = clean; m_cnt = 0; m_bouncy = clean;
            m_busy = 1'b1; m_bounce_st = 1'b1;
          end else begin
            m_bouncy = 1'b0; m_level = 1'b0; m_done = 1'b1;
          end
        end
      end else if (clean != m_target) begin
        m_target = clean; m_cnt = 0; m_bouncy = clean;
      end else if (m_cnt == LIMIT - 1) begin
        m_bouncy = m_target; m_level = m_target;
        m_busy = 1'b0; m_done = 1'b1; m_bounce_st = 1'b0;
      end else begin
        if (m_cnt % DIV == DIV - 1) m_bouncy = cur[0];
        m_cnt++;
      end
    end
  endtask

  task automatic tick(input logic clean, input logic rst);
    obs_t e, o;
    emu_if.i_Clean = clean;
    reset = rst;
    model_step(clean, rst);
    e.bouncy = m_bouncy; e.busy = m_busy; e.done = m_done;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o.bouncy = emu_if.o_Bouncy; o.busy = emu_if.o_Busy; o.done = emu_if.o_Done;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %b, expected an entry", o);
    end else begin
      e = sb_q.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL cycle t=%0t {bouncy,busy,done}: observed %b, expected %b", $time, o, e);
      end
    end
    busy_cnt += int'(o.busy);
    done_cnt += int'(o.done);
    if (rec_mode == 1 && rec_idx < LIMIT) begin
      rec_a[rec_idx] = o.bouncy; rec_idx++;
    end else if (rec_mode == 2 && rec_idx < LIMIT) begin
      rec_b[rec_idx] = o.bouncy; rec_idx++;
    end
  endtask

  initial begin
    logic clean;
    int   base, diffs;
    emu_if.i_Clean = 1'b1;

    // reset held with clean high: outputs stay low
    busy_cnt = 0; done_cnt = 0;
    repeat (3) tick(1'b1, 1'b1);
    check("reset_busy", busy_cnt, 0);
    check("reset_done", done_cnt, 0);

    // press window starts on the first edge after release
    busy_cnt = 0; done_cnt = 0; rec_mode = 1; rec_idx = 0;
    repeat (LIMIT + 6) tick(1'b1, 1'b0);
    rec_mode = 0;
    check("press_busy_cycles", busy_cnt, LIMIT);
    check("press_done_pulses", done_cnt, 1);
    check("press_settled", int'(emu_if.o_Bouncy), 1);

    // release: immediate unless release bouncing is built in
    busy_cnt = 0; done_cnt = 0;
    repeat (LIMIT + 6) tick(1'b0, 1'b0);
    check("release_busy_cycles", busy_cnt, RELEASE_BOUNCES ? LIMIT : 0);
    check("release_done_pulses", done_cnt, 1);
    check("release_settled", int'(emu_if.o_Bouncy), 0);

    // retrigger: edge that sees counter=20 flips clean back to 0
    busy_cnt = 0; done_cnt = 0;
    repeat (21) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("retrig_immediate", int'(emu_if.o_Bouncy), 0);
    check("retrig_still_busy", int'(emu_if.o_Busy), 1);
    repeat (LIMIT + 6) tick(1'b0, 1'b0);
    // cycles showing counter 0..20, then a full restarted window
    check("retrig_busy_cycles", busy_cnt, 21 + LIMIT);
    check("retrig_done_pulses", done_cnt, 1);
    check("retrig_settled", int'(emu_if.o_Bouncy), 0);

    // reset at counter=30 aborts the window silently
    repeat (31) tick(1'b1, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    tick(1'b1, 1'b1);
    check("abort_bouncy", int'(emu_if.o_Bouncy), 0);
    check("abort_busy", int'(emu_if.o_Busy), 0);
    check("abort_done", done_cnt, 0);
    rec_mode = 2; rec_idx = 0;
    repeat (LIMIT + 6) tick(1'b1, 1'b0);
    rec_mode = 0;
    diffs = 0;
    for (int i = 0; i < LIMIT; i++) diffs += int'(rec_a[i] !== rec_b[i]);
    check("lfsr_replay_diffs", diffs, 0);
    check("abort_rewindow_done", done_cnt, 1);

    // loopback into a 128-cycle debounce filter
    repeat (200) tick(1'b1, 1'b0);
    check("filter_initial", int'(f_state), 1);
    base  = f_toggles;
    clean = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clean = ~clean;
      repeat (300) tick(clean, 1'b0);
      check("filter_level", int'(f_state), int'(clean));
      check("filter_toggles", f_toggles - base, i + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
